imem_boot_loader: RTL and testbench

Upstream feeder for the CPU core. Receives a byte stream carrying a program image, packs the bytes into 32-bit little-endian words, and writes them sequentially into instruction memory. It holds the CPU in reset until the whole image is written, then releases it. Sits between the host/test byte source and the CPU's instruction memory and reset input.

---
 rtl/boot_pkg.sv | 19 +
 rtl/byte_packer.sv | 57 +++++
 rtl/imem_boot_loader.sv | 127 ++++++++++++
 tb/tb_imem_boot_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
package boot_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_W      = BYTE_W * HDR_BYTES;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } boot_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes LSB-first into 32-bit words; presents each finished word for one cycle.
module byte_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_last_c,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;

    assign word_last_c = byte_en && (idx_q == IDX_W'(WORD_BYTES - 1));
    assign word_valid  = word_valid_q;
    assign word        = word_q;

    // Drop the byte into its lane; the fourth byte completes and publishes the word.
    always_comb begin
        idx_d        = idx_q;
        asm_d        = asm_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (byte_en) begin
            for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    asm_d[k*BYTE_W +: BYTE_W] = byte_in;
                end
            end
            idx_d = idx_q + IDX_W'(1);
            if (word_last_c) begin
                word_d       = asm_d;
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q        <= '0;
            asm_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the CPU from reset.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(2 ** ADDR_W);

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic              byte_en;
    logic              word_last_c;
    logic              last_word;
    logic [LEN_W-1:0]  len_full;

    assign accept    = in_valid && in_ready_q;
    assign byte_en   = accept && (state_q == DATA);
    assign len_full  = {in_data, len_q[BYTE_W-1:0]};
    assign last_word = (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)));

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .byte_en     (byte_en),
        .byte_in     (in_data),
        .word_last_c (word_last_c),
        .word_valid  (imem_we),
        .word        (imem_wdata)
    );

    // Header parse, word sequencing and registered status outputs.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        imem_addr_d = imem_addr_q;
        case (state_q)
            LEN_LO: begin
                if (accept) begin
                    len_d[BYTE_W-1:0] = in_data;
                    state_d           = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_last_c) begin
                    imem_addr_d = word_idx_q;
                    word_idx_d  = word_idx_q + ADDR_W'(1);
                end
                // in_ready is low only while the final word is being written.
                if (imem_we && !in_ready_q) begin
                    state_d = DONE;
                end
            end
            DONE, ERR: begin
            end
            default: state_d = LEN_LO;
        endcase

        in_ready_d = ((state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA))
                     && !(word_last_c && last_word);
        cpu_rst_d  = (state_d != DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LEN_LO;
            len_q       <= '0;
            word_idx_q  <= '0;
            imem_addr_q <= '0;
            in_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            imem_addr_q <= imem_addr_d;
            in_ready_q  <= in_ready_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_addr = imem_addr_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: header parsing, word writes, completion, error and reset cases.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_wr     = 0;
    int          done_cyc = -1;
    int          acc_cyc  = 0;
    int          wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    logic        wr_rdy  [0:511];
    int          wr_cyc  [0:511];

    logic [7:0] img1 [0:9] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] img5 [0:5] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Write monitor: every imem_we cycle is logged with its cycle stamp.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we === 1'b1) begin
            if (n_wr < 512) begin
                wr_addr[n_wr] = int'(imem_addr);
                wr_data[n_wr] = imem_wdata;
                wr_rdy[n_wr]  = in_ready;
                wr_cyc[n_wr]  = cyc;
            end
            n_wr = n_wr + 1;
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        n_wr     = 0;
        done_cyc = -1;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        logic got;
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy === 1'b1) got = 1'b1;
        end
        acc_cyc = cyc + 1;
        #1;
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int t = 0; t < budget && done !== 1'b1; t++) @(negedge clk);
        chk(tag, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_img1(input string tag);
        chk({tag, "_nwr"}, 32'(n_wr), 32'd2);
        chk({tag, "_addr0"}, 32'(wr_addr[0]), 32'd0);
        chk({tag, "_data0"}, wr_data[0], 32'h0000_0013);
        chk({tag, "_addr1"}, 32'(wr_addr[1]), 32'd1);
        chk({tag, "_data1"}, wr_data[1], 32'h0010_0093);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(wr_cyc[1] + 1));
        chk({tag, "_last_rdy"}, 32'(wr_rdy[1]), 32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int bad;
        int w0;

        // Test 1: two-word image, continuous valid
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(img1[i], 0);
        wait_done("t1_done", 20);
        check_img1("t1");
        chk("t1_rdy_mid", 32'(wr_rdy[0]), 32'd1);

        // Test 6: traffic after DONE is ignored
        w0 = n_wr;
        bad = 0;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0) bad++;
        end
        chk("t6_bad_cycles", 32'(bad), 32'd0);
        chk("t6_nwr", 32'(n_wr), 32'(w0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Test 2: empty image
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        #1;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_in_ready_later", 32'(in_ready), 32'd0);
        chk("t2_nwr", 32'(n_wr), 32'd0);

        // Test 3a: N=257 exceeds capacity
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        #1;
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        chk("t3_nwr", 32'(n_wr), 32'd0);
        chk("t3_error_hold", 32'(error), 32'd1);

        // Test 3b: N=256 fills the whole memory
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        #1;
        chk("t3b_in_ready", 32'(in_ready), 32'd1);
        chk("t3b_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 0);
            send_byte(8'hA5, 0);
            send_byte(~8'(i), 0);
            send_byte(8'h5A, 0);
        end
        wait_done("t3b_done", 20);
        repeat (4) @(negedge clk);
        chk("t3b_nwr", 32'(n_wr), 32'd256);
        for (int i = 0; i < 256; i++) begin
            chk("t3b_addr", 32'(wr_addr[i]), 32'(i));
            chk("t3b_data", wr_data[i], {8'h5A, ~8'(i), 8'hA5, 8'(i)});
        end
        chk("t3b_cpu_rst", 32'(cpu_rst), 32'd0);
        @(posedge clk);
        #1;

        // Test 4: same image, valid every third cycle
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(img1[i], 2);
        wait_done("t4_done", 20);
        check_img1("t4");

        // Test 5: abort mid-load, then a fresh one-word image
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1), 0);
        @(negedge clk);
        #1;
        chk("t5_partial_nwr", 32'(n_wr), 32'd1);
        chk("t5_partial_data", wr_data[0], 32'h4433_2211);
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img5[i], 0);
        wait_done("t5_done", 20);
        chk("t5_nwr", 32'(n_wr), 32'd1);
        chk("t5_addr", 32'(wr_addr[0]), 32'd0);
        chk("t5_data", wr_data[0], 32'hDEAD_BEEF);
        chk("t5_cpu_rst", 32'(cpu_rst), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
